regfile_csr_unit: RTL and testbench

//  Parametrised integer register file plus machine-mode CSR file with trap entry/return and 64-bit counters.

---
 rtl/regcsr_pkg.sv | 32 +++
 rtl/csr_file.sv | 134 +++++++++++++
 rtl/regfile_csr_unit.sv | 85 ++++++++
 tb/tb_regfile_csr_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regcsr_pkg.sv
// rtl/regcsr_pkg.sv - shared CSR addresses, operation encoding and field positions
package regcsr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    localparam int MCAUSE_ECALL_M = 11;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;

    // RS/RC with a zero operand are pure reads and never modify the CSR.
    function automatic logic csr_is_write(input csr_op_e op, input logic operand_nonzero);
        return (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && operand_nonzero);
    endfunction

endpackage

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSRs, 64-bit counters, trap entry/return and access decode
module csr_file
    import regcsr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] VENDOR_ID = '0,
    parameter logic [XLEN-1:0] ARCH_ID   = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [11:0]     csr_addr,
    input  csr_op_e         csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic [XLEN-1:0] pc,
    input  logic            ecall,
    input  logic            mret,
    input  logic            retire,
    output logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] epc
);

    logic              mie;
    logic              mpie;
    logic [XLEN-1:0]   mtvec;
    logic [XLEN-1:0]   mscratch;
    logic [XLEN-1:0]   mepc;
    logic [XLEN-1:0]   mcause;
    logic [2*XLEN-1:0] mcycle;
    logic [2*XLEN-1:0] minstret;

    logic            implemented;
    logic            read_only;
    logic            wr_req;
    logic            csr_we;
    logic [XLEN-1:0] new_val;

    always_comb begin
        csr_rdata   = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie;
                csr_rdata[MSTATUS_MPIE] = mpie;
            end
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MSCRATCH:  csr_rdata = mscratch;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MCYCLE:    csr_rdata = mcycle[XLEN-1:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET:  csr_rdata = minstret[XLEN-1:0];
            CSR_MINSTRETH: csr_rdata = minstret[2*XLEN-1:XLEN];
            CSR_MVENDORID: csr_rdata = VENDOR_ID;
            CSR_MARCHID:   csr_rdata = ARCH_ID;
            default:       implemented = 1'b0;
        endcase
    end

    // The 0xC00-0xFFF quadrant is read-only by address encoding.
    assign read_only   = (csr_addr[11:10] == 2'b11);
    assign wr_req      = csr_is_write(csr_op, |csr_wdata);
    assign csr_illegal = (csr_op != CSR_NONE) && (!implemented || (read_only && wr_req));
    assign csr_we      = wr_req && !csr_illegal && !ecall && !mret;

    always_comb begin
        new_val = csr_rdata;
        case (csr_op)
            CSR_RW:  new_val = csr_wdata;
            CSR_RS:  new_val = csr_rdata | csr_wdata;
            CSR_RC:  new_val = csr_rdata & ~csr_wdata;
            default: new_val = csr_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (ecall) begin
            mepc   <= pc & ~XLEN'(3);
            mcause <= XLEN'(MCAUSE_ECALL_M);
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie  <= new_val[MSTATUS_MIE];
                    mpie <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec    <= new_val;
                CSR_MSCRATCH: mscratch <= new_val;
                CSR_MEPC:     mepc     <= new_val & ~XLEN'(3);
                CSR_MCAUSE:   mcause   <= new_val;
                default: ;
            endcase
        end
    end

    // A write to either counter half replaces it and stalls that counter for the cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_addr == CSR_MCYCLE)
                mcycle[XLEN-1:0] <= new_val;
            else if (csr_we && csr_addr == CSR_MCYCLEH)
                mcycle[2*XLEN-1:XLEN] <= new_val;
            else
                mcycle <= mcycle + 1'b1;

            if (csr_we && csr_addr == CSR_MINSTRET)
                minstret[XLEN-1:0] <= new_val;
            else if (csr_we && csr_addr == CSR_MINSTRETH)
                minstret[2*XLEN-1:XLEN] <= new_val;
            else if (retire)
                minstret <= minstret + 1'b1;
        end
    end

    assign trap_vec = mtvec & ~XLEN'(3);
    assign epc      = mepc;

endmodule

// File: rtl/regfile_csr_unit.sv
// rtl/regfile_csr_unit.sv - integer register file with write bypass plus machine CSR file
module regfile_csr_unit
    import regcsr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NREG      = 32,
    parameter int              BYPASS    = 1,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] VENDOR_ID = '0,
    parameter logic [XLEN-1:0] ARCH_ID   = '0,
    localparam int             AW        = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] a0_value,
    input  logic            rd_wen,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic [XLEN-1:0] pc,
    input  logic            ecall,
    input  logic            mret,
    input  logic            retire,
    output logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] epc
);

    logic [XLEN-1:0] regs [NREG];
    logic            rd_live;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (rd_wen && rd_addr != '0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rd_live = (BYPASS != 0) && rd_wen && (rd_addr != '0);

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        if (rd_live && rd_addr == rs1_addr)
            rs1_data = rd_data;
    end

    always_comb begin
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        if (rd_live && rd_addr == rs2_addr)
            rs2_data = rd_data;
    end

    assign a0_value = regs[10];

    csr_file #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST),
        .VENDOR_ID (VENDOR_ID),
        .ARCH_ID   (ARCH_ID)
    ) u_csr_file (
        .clock       (clock),
        .reset       (reset),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op_e'(csr_op)),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .pc          (pc),
        .ecall       (ecall),
        .mret        (mret),
        .retire      (retire),
        .trap_vec    (trap_vec),
        .epc         (epc)
    );

endmodule

// File: tb/tb_regfile_csr_unit.sv
// tb/tb_regfile_csr_unit.sv - directed and randomized checks of regfile_csr_unit against a reference model
module tb_regfile_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] VID       = 32'h0000_0489;
    localparam logic [31:0] AID       = 32'h0000_0017;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_wen;
    logic [31:0] rd_data;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, pc;
    logic        ecall, mret, retire;

    logic [31:0] rs1_data, rs2_data, a0_value, csr_rdata, trap_vec, epc;
    logic        csr_illegal;
    logic [31:0] b0_rs1_data, b0_rs2_data, b0_a0_value, b0_csr_rdata, b0_trap_vec, b0_epc;
    logic        b0_csr_illegal;

    regfile_csr_unit #(.BYPASS(1), .MTVEC_RST(MTVEC_RST), .VENDOR_ID(VID), .ARCH_ID(AID)) dut (
        .clock(clock), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .a0_value(a0_value),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .pc(pc),
        .ecall(ecall), .mret(mret), .retire(retire), .trap_vec(trap_vec), .epc(epc)
    );

    regfile_csr_unit #(.BYPASS(0), .MTVEC_RST(MTVEC_RST), .VENDOR_ID(VID), .ARCH_ID(AID)) dut_nb (
        .clock(clock), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data), .a0_value(b0_a0_value),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_data(rd_data),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(b0_csr_rdata), .csr_illegal(b0_csr_illegal), .pc(pc),
        .ecall(ecall), .mret(mret), .retire(retire), .trap_vec(b0_trap_vec), .epc(b0_epc)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic [31:0] m_regs [32];
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {implemented, value}
    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'hB00: return {1'b1, m_mcycle[31:0]};
            12'hB80: return {1'b1, m_mcycle[63:32]};
            12'hB02: return {1'b1, m_minstret[31:0]};
            12'hB82: return {1'b1, m_minstret[63:32]};
            12'hF11: return {1'b1, VID};
            12'hF12: return {1'b1, AID};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    function automatic logic m_wants_write();
        return (csr_op == 2'd1) || (csr_op >= 2'd2 && csr_wdata != 32'h0);
    endfunction

    function automatic logic m_illegal();
        logic [32:0] r;
        r = m_read(csr_addr);
        return (csr_op != 2'd0) &&
               (!r[32] || ((csr_addr == 12'hF11 || csr_addr == 12'hF12) && m_wants_write()));
    endfunction

    task automatic m_commit();
        logic [32:0] r;
        logic        wr;
        logic [31:0] nv;
        logic [63:0] cyc, ins;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_mie = 1'b0; m_mpie = 1'b0;
            m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_mcycle = 0; m_minstret = 0;
            return;
        end
        r  = m_read(csr_addr);
        wr = m_wants_write() && !m_illegal() && !ecall && !mret;
        case (csr_op)
            2'd1:    nv = csr_wdata;
            2'd2:    nv = r[31:0] | csr_wdata;
            2'd3:    nv = r[31:0] & ~csr_wdata;
            default: nv = r[31:0];
        endcase
        cyc = m_mcycle + 64'd1;
        ins = m_minstret + 64'(retire);
        if (wr) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause = nv;
                12'hB00: cyc = {m_mcycle[63:32], nv};
                12'hB80: cyc = {nv, m_mcycle[31:0]};
                12'hB02: ins = {m_minstret[63:32], nv};
                12'hB82: ins = {nv, m_minstret[31:0]};
                default: ;
            endcase
        end
        if (ecall) begin
            m_mepc = pc & 32'hFFFF_FFFC; m_mcause = 32'd11;
            m_mpie = m_mie; m_mie = 1'b0;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1'b1;
        end
        m_mcycle = cyc;
        m_minstret = ins;
        if (rd_wen && rd_addr != 5'd0) m_regs[rd_addr] = rd_data;
    endtask

    task automatic compare_all();
        logic [32:0] r;
        logic [31:0] e1, e2;
        r  = m_read(csr_addr);
        e1 = (rd_wen && rd_addr == rs1_addr && rs1_addr != 5'd0) ? rd_data : m_regs[rs1_addr];
        e2 = (rd_wen && rd_addr == rs2_addr && rs2_addr != 5'd0) ? rd_data : m_regs[rs2_addr];
        chk("rs1_bypass", rs1_data, e1);
        chk("rs2_bypass", rs2_data, e2);
        chk("rs1_nobypass", b0_rs1_data, m_regs[rs1_addr]);
        chk("rs2_nobypass", b0_rs2_data, m_regs[rs2_addr]);
        chk("a0_value", a0_value, m_regs[10]);
        if (r[32]) chk("csr_rdata", csr_rdata, r[31:0]);
        chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, m_illegal()});
        chk("trap_vec", trap_vec, m_mtvec & 32'hFFFF_FFFC);
        chk("epc", epc, m_mepc);
    endtask

    task automatic step();
        #4;
        if (checking) compare_all();
        @(posedge clock);
        m_commit();
        #1;
    endtask

    task automatic idle_inputs();
        rd_wen = 0; csr_op = 0; ecall = 0; mret = 0; retire = 0; csr_wdata = 0;
    endtask

    task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    logic [11:0] csr_list [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                   12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h7C0};

    initial begin
        reset = 1; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rd_data = 0;
        csr_addr = 12'h305; pc = 0;
        idle_inputs();
        @(posedge clock); #1;
        step();
        checking = 1'b1;
        reset = 0;

        // reset state
        #1;
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_a0", a0_value, 32'h0);
        chk("rst_trap_vec", trap_vec, 32'h0000_1000);
        chk("rst_epc", epc, 32'h0);
        csr_check("rst_mtvec", 12'h305, MTVEC_RST);
        csr_check("rst_mstatus", 12'h300, 32'h0);

        // register write / read-back / x0
        rd_wen = 1; rd_addr = 10; rd_data = 32'hDEAD_BEEF;
        step();
        rd_wen = 0; rs1_addr = 10; rs2_addr = 10;
        #1;
        chk("x10_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("x10_rs2", rs2_data, 32'hDEAD_BEEF);
        chk("x10_a0", a0_value, 32'hDEAD_BEEF);
        rd_wen = 1; rd_addr = 0; rd_data = 5;
        step();
        rd_wen = 0; rs1_addr = 0;
        #1;
        chk("x0_zero", rs1_data, 32'h0);

        // same-cycle bypass
        rd_wen = 1; rd_addr = 3; rd_data = 32'h55; rs1_addr = 3;
        #1;
        chk("bypass_on", rs1_data, 32'h55);
        chk("bypass_off", b0_rs1_data, 32'h0);
        step();
        rd_wen = 0;

        // mscratch read-modify-write
        csr_op = 1; csr_addr = 12'h340; csr_wdata = 32'hF0F0;
        #1; chk("rmw_rw_old", csr_rdata, 32'h0);
        step();
        csr_op = 2; csr_wdata = 32'h000F;
        #1; chk("rmw_rs_old", csr_rdata, 32'hF0F0);
        step();
        csr_op = 3; csr_wdata = 32'h00F0;
        #1; chk("rmw_rc_old", csr_rdata, 32'hF0FF);
        step();
        csr_op = 0; csr_wdata = 0;
        #1; chk("rmw_final", csr_rdata, 32'hF00F);

        // trap entry and return
        csr_op = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
        step();
        csr_op = 0; ecall = 1; pc = 32'h8000_0010;
        step();
        ecall = 0;
        #1; chk("ecall_epc", epc, 32'h8000_0010);
        csr_check("ecall_mcause", 12'h342, 32'd11);
        csr_check("ecall_mstatus", 12'h300, 32'h80);
        mret = 1;
        step();
        mret = 0;
        csr_check("mret_mstatus", 12'h300, 32'h88);

        // read-only and unimplemented CSRs, trap vs CSR write
        csr_op = 1; csr_addr = 12'hF11; csr_wdata = 5;
        #1; chk("ro_rw_illegal", {31'b0, csr_illegal}, 32'h1);
        step();
        csr_op = 0;
        csr_check("ro_unchanged", 12'hF11, VID);
        csr_op = 2; csr_wdata = 0;
        #1; chk("ro_rs0_legal", {31'b0, csr_illegal}, 32'h0);
        csr_op = 1; csr_addr = 12'h7C0; csr_wdata = 1;
        #1; chk("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
        step();
        csr_op = 1; csr_addr = 12'h340; csr_wdata = 32'h1234; ecall = 1; pc = 32'h100;
        step();
        idle_inputs();
        csr_check("trap_blocks_write", 12'h340, 32'hF00F);
        chk("trap_epc", epc, 32'h100);
        csr_check("trap_mstatus", 12'h300, 32'h80);

        // counter carry and minstret, from a fresh reset
        reset = 1;
        step();
        reset = 0; retire = 1;
        csr_op = 1; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
        step();
        csr_addr = 12'hB80; csr_wdata = 0;
        step();
        csr_op = 0;
        step();
        step();
        retire = 0;
        csr_check("mcycleh_carry", 12'hB80, 32'h1);
        csr_check("mcycle_lo", 12'hB00, 32'h1);
        csr_check("minstret_4", 12'hB02, 32'h4);
        csr_check("minstreth_0", 12'hB82, 32'h0);

        // randomized traffic checked every cycle against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            rs1_addr  = 5'($urandom);
            rs2_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            rd_wen    = 1'($urandom);
            rd_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom);
            rd_data   = $urandom;
            csr_addr  = csr_list[$urandom_range(0, 11)];
            csr_op    = 2'($urandom);
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            pc        = $urandom;
            ecall     = ($urandom_range(0, 15) == 0);
            mret      = ($urandom_range(0, 15) == 0);
            retire    = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
